// File: rtl/aes_round_sched.sv
// AES encrypt round sequencer: walks AddRoundKey / ByteSub_ShiftRow / MixColumn
// through nr rounds using HLS-style start/done handshakes, and presents one upward.
module aes_round_sched #(
  parameter int RW = 6
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  input  logic [3:0]    nr,
  output logic          cfg_err,
  output logic          ark_start,
  input  logic          ark_done,
  output logic [RW-1:0] ark_n,
  output logic          sub_start,
  input  logic          sub_done,
  output logic          mix_start,
  input  logic          mix_done,
  output logic [3:0]    round
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    ARK  = 5'b00010,
    SUB  = 5'b00100,
    MIX  = 5'b01000,
    FIN  = 5'b10000
  } state_t;

  state_t     state;
  logic [3:0] nr_q;
  logic       nr_legal;

  assign nr_legal = (nr == 4'd10) || (nr == 4'd12) || (nr == 4'd14);

  // Each child's done is only looked at in its own phase; idle children report done=1.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      round   <= 4'd0;
      nr_q    <= 4'd0;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            if (nr_legal) begin
              nr_q    <= nr;
              round   <= 4'd0;
              cfg_err <= 1'b0;
              state   <= ARK;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ARK: begin
          if (ark_done) begin
            if (round == nr_q) begin
              state <= FIN;
            end else begin
              round <= round + 4'd1;
              state <= SUB;
            end
          end
        end
        SUB: begin
          if (sub_done) begin
            state <= (round == nr_q) ? ARK : MIX;
          end
        end
        MIX: begin
          if (mix_done) begin
            state <= ARK;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The final round skips MixColumn, so SUB returns straight to ARK when round==nr_q.
  assign ark_start = (state == ARK);
  assign sub_start = (state == SUB);
  assign mix_start = (state == MIX);
  assign ark_n     = RW'(round);

  assign ap_done  = (state == FIN) || ((state == IDLE) && ap_start && !nr_legal);
  assign ap_ready = ap_done;
  assign ap_idle  = (state == IDLE) && !ap_start;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: table of whole runs with modelled
// child latencies, plus directed sequences for reset, spurious dones and back-to-back.
module tb_aes_round_sched;

  localparam int RW = 6;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [3:0]    nr;
  logic          cfg_err;
  logic          ark_start;
  logic          ark_done;
  logic [RW-1:0] ark_n;
  logic          sub_start;
  logic          sub_done;
  logic          mix_start;
  logic          mix_done;
  logic [3:0]    round;

  aes_round_sched #(.RW(RW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .nr(nr), .cfg_err(cfg_err),
    .ark_start(ark_start), .ark_done(ark_done), .ark_n(ark_n),
    .sub_start(sub_start), .sub_done(sub_done),
    .mix_start(mix_start), .mix_done(mix_done), .round(round)
  );

  always #5 ap_clk = ~ap_clk;

  // Child models: done rises in the lat-th cycle of start; *_extra injects stray dones.
  int   ark_lat = 1, sub_lat = 1, mix_lat = 1;
  int   ark_cnt = 0, sub_cnt = 0, mix_cnt = 0;
  logic ark_extra = 1'b0, sub_extra = 1'b0, mix_extra = 1'b0;

  assign ark_done = (ark_start && ark_cnt == ark_lat - 1) || ark_extra;
  assign sub_done = (sub_start && sub_cnt == sub_lat - 1) || sub_extra;
  assign mix_done = (mix_start && mix_cnt == mix_lat - 1) || mix_extra;

  always @(posedge ap_clk) begin
    ark_cnt <= (ark_start && !ark_done) ? ark_cnt + 1 : 0;
    sub_cnt <= (sub_start && !sub_done) ? sub_cnt + 1 : 0;
    mix_cnt <= (mix_start && !mix_done) ? mix_cnt + 1 : 0;
  end

  int            call_log[$];
  int            ark_calls, sub_calls, mix_calls, start_cycles, multi_err, stab_err;
  logic          ark_prev = 1'b0;
  logic [RW-1:0] ark_first;

  // Record completed child calls and protocol violations mid-cycle.
  always @(negedge ap_clk) begin
    if (int'(ark_start) + int'(sub_start) + int'(mix_start) > 1) multi_err++;
    if (ark_start || sub_start || mix_start) start_cycles++;
    if (ark_start && !ark_prev) ark_first = ark_n;
    else if (ark_start && ark_n != ark_first) stab_err++;
    ark_prev = ark_start;
    if (ark_start && ark_done) begin ark_calls++; call_log.push_back(100 + int'(ark_n)); end
    if (sub_start && sub_done) begin sub_calls++; call_log.push_back(200); end
    if (mix_start && mix_done) begin mix_calls++; call_log.push_back(300); end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    call_log.delete();
    ark_calls = 0; sub_calls = 0; mix_calls = 0;
    start_cycles = 0; multi_err = 0; stab_err = 0;
  endtask

  // Called just after a posedge; cycles counts cycles since the accept edge.
  task automatic waitDone(input int start_cyc, output int cycles);
    int c;
    bit got;
    c = start_cyc;
    got = 0;
    while (!got && c < 3000) begin
      @(negedge ap_clk);
      if (ap_done) got = 1;
      else begin
        @(posedge ap_clk);
        c++;
      end
    end
    cycles = got ? c : -1;
  endtask

  typedef struct {
    int nr;
    int lat;
    int exp_cycles;
    int exp_ark;
    int exp_sub;
    int exp_mix;
    int exp_err;
  } vec_t;

  task automatic applyStimulus(input vec_t v);
    int    cycles;
    int    first_bad;
    int    exp_log[$];
    string tag;
    tag = $sformatf("nr%0d_lat%0d", v.nr, v.lat);
    @(negedge ap_clk);
    nr = 4'(v.nr);
    ark_lat = v.lat; sub_lat = v.lat; mix_lat = v.lat;
    clearMonitor();
    ap_start = 1'b1;
    #1;
    checkOutput({tag, "_accept_done"}, int'(ap_done), v.exp_err);
    checkOutput({tag, "_accept_ready"}, int'(ap_ready), v.exp_err);
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    if (v.exp_err != 0) begin
      @(negedge ap_clk);
      checkOutput({tag, "_cfg_err"}, int'(cfg_err), 1);
      checkOutput({tag, "_idle_after_err"}, int'(ap_idle), 1);
      checkOutput({tag, "_done_after_err"}, int'(ap_done), 0);
      checkOutput({tag, "_start_cycles"}, start_cycles, 0);
      return;
    end
    waitDone(1, cycles);
    checkOutput({tag, "_done_cycle"}, cycles, v.exp_cycles);
    checkOutput({tag, "_ready"}, int'(ap_ready), 1);
    checkOutput({tag, "_final_round"}, int'(round), v.nr);
    checkOutput({tag, "_cfg_err"}, int'(cfg_err), 0);
    checkOutput({tag, "_ark_calls"}, ark_calls, v.exp_ark);
    checkOutput({tag, "_sub_calls"}, sub_calls, v.exp_sub);
    checkOutput({tag, "_mix_calls"}, mix_calls, v.exp_mix);
    checkOutput({tag, "_ark_n_stable"}, stab_err, 0);
    checkOutput({tag, "_one_start"}, multi_err, 0);
    exp_log.push_back(100);
    for (int i = 1; i <= v.nr; i++) begin
      exp_log.push_back(200);
      if (i < v.nr) exp_log.push_back(300);
      exp_log.push_back(100 + i);
    end
    first_bad = -1;
    for (int i = 0; i < exp_log.size(); i++) begin
      if (first_bad < 0 && (i >= call_log.size() || call_log[i] != exp_log[i])) first_bad = i;
    end
    if (first_bad < 0 && call_log.size() != exp_log.size()) first_bad = exp_log.size();
    checkOutput({tag, "_call_order_first_bad"}, first_bad, -1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput({tag, "_idle_after_fin"}, int'(ap_idle), 1);
    checkOutput({tag, "_done_after_fin"}, int'(ap_done), 0);
  endtask

  vec_t vecs[9];
  vec_t v_restart;

  initial begin
    int cycles;
    bit found;

    // Cycles = (ARK+SUB+MIX calls) * phase length + 1 FIN cycle.
    vecs[0] = '{10, 1,  31, 11, 10,  9, 0};
    vecs[1] = '{12, 1,  37, 13, 12, 11, 0};
    vecs[2] = '{14, 1,  43, 15, 14, 13, 0};
    vecs[3] = '{14, 5, 211, 15, 14, 13, 0};
    vecs[4] = '{ 7, 1,   0,  0,  0,  0, 1};
    vecs[5] = '{12, 2,  73, 13, 12, 11, 0};
    vecs[6] = '{ 0, 1,   0,  0,  0,  0, 1};
    vecs[7] = '{15, 1,   0,  0,  0,  0, 1};
    vecs[8] = '{11, 1,   0,  0,  0,  0, 1};
    v_restart = '{10, 1, 31, 11, 10, 9, 0};

    ap_rst = 1'b1;
    ap_start = 1'b0;
    nr = 4'd0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("reset_idle", int'(ap_idle), 1);
    checkOutput("reset_done", int'(ap_done), 0);
    checkOutput("reset_ready", int'(ap_ready), 0);
    checkOutput("reset_starts", int'({ark_start, sub_start, mix_start}), 0);
    checkOutput("reset_round", int'(round), 0);
    checkOutput("reset_cfg_err", int'(cfg_err), 0);
    ap_rst = 1'b0;

    // A stuck-high ark_done while idle must not move the FSM.
    ark_extra = 1'b1;
    repeat (5) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("stuck_ark_done_idle", int'(ap_idle), 1);
    checkOutput("stuck_ark_done_start", int'(ark_start), 0);
    checkOutput("stuck_ark_done_round", int'(round), 0);
    ark_extra = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Stray sub/mix dones during the first ARK phase are ignored.
    @(negedge ap_clk);
    nr = 4'd10;
    ark_lat = 4; sub_lat = 4; mix_lat = 4;
    clearMonitor();
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    sub_extra = 1'b1;
    mix_extra = 1'b1;
    @(posedge ap_clk);
    #1 sub_extra = 1'b0;
    mix_extra = 1'b0;
    checkOutput("spurious_still_ark", int'(ark_start), 1);
    checkOutput("spurious_no_sub", int'(sub_start), 0);
    checkOutput("spurious_ark_n", int'(ark_n), 0);
    waitDone(2, cycles);
    checkOutput("spurious_done_cycle", cycles, 121);
    checkOutput("spurious_ark_calls", ark_calls, 11);
    checkOutput("spurious_mix_calls", mix_calls, 9);

    // Reset during MIX of round 5, then a clean restart from ARK(0).
    @(posedge ap_clk);
    @(negedge ap_clk);
    nr = 4'd10;
    ark_lat = 3; sub_lat = 3; mix_lat = 3;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge ap_clk);
      if (mix_start && round == 4'd5) found = 1;
    end
    checkOutput("reach_mix_round5", int'(found), 1);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    checkOutput("midrun_rst_mix_start", int'(mix_start), 0);
    checkOutput("midrun_rst_any_start", int'({ark_start, sub_start, mix_start}), 0);
    checkOutput("midrun_rst_round", int'(round), 0);
    checkOutput("midrun_rst_idle", int'(ap_idle), 1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    applyStimulus(v_restart);

    // ap_start held through FIN: the next run is accepted the cycle after FIN.
    @(negedge ap_clk);
    nr = 4'd12;
    ark_lat = 1; sub_lat = 1; mix_lat = 1;
    ap_start = 1'b1;
    @(posedge ap_clk);
    waitDone(1, cycles);
    checkOutput("b2b_first_done_cycle", cycles, 37);
    @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("b2b_idle_low", int'(ap_idle), 0);
    checkOutput("b2b_done_low", int'(ap_done), 0);
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    checkOutput("b2b_ark_start", int'(ark_start), 1);
    checkOutput("b2b_ark_n", int'(ark_n), 0);
    waitDone(1, cycles);
    checkOutput("b2b_second_done_cycle", cycles, 37);
    @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("b2b_final_idle", int'(ap_idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
